// File: rtl/clock_compare_unit.sv
// clock_compare_unit: clock support and result check for the TRNG BIST datapath.
// Builds a gated divided clock (ro_clk) and a free-running strobe (fast_tick)
// from clk, and compares the hash word against the wrapper word, giving the
// per-bit mismatch vector for the MISR together with summary flags.
// Optional feature macro: CCU_STICKY_ERR_EN (sticky error flag register).
// Reset: synchronous, active-low (rst).

module clock_compare_unit #(
   parameter int unsigned WIDTH    = 64,
   parameter int unsigned RO_HALF  = 4,
   parameter int unsigned FAST_DIV = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           en,
   input  logic [WIDTH-1:0]               i1,
   input  logic [WIDTH-1:0]               i2,
   output logic                           ro_clk,
   output logic                           fast_tick,
   output logic [WIDTH-1:0]               o,
   output logic                           mismatch,
   output logic [$clog2(WIDTH+1)-1:0]     diff_cnt,
   output logic                           err_sticky
);

   // Counter widths: $clog2 of the modulus, never narrower than one bit.
   localparam int unsigned RO_W   = (RO_HALF  > 1) ? $clog2(RO_HALF)  : 1;
   localparam int unsigned FAST_W = (FAST_DIV > 1) ? $clog2(FAST_DIV) : 1;
   localparam int unsigned CNT_W  = $clog2(WIDTH + 1);

   localparam logic [RO_W-1:0]   RO_LAST   = RO_W'(RO_HALF - 1);
   localparam logic [FAST_W-1:0] FAST_LAST = FAST_W'(FAST_DIV - 1);

   logic [RO_W-1:0]   ro_cnt;
   logic [FAST_W-1:0] fast_cnt;
   logic [WIDTH-1:0]  diff_c;
   logic [CNT_W-1:0]  pop_c;

   // RO clock divider: counts while enabled, toggles at the half period,
   // and drops straight to the low phase with a cleared count when disabled.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ro_cnt <= '0;
         ro_clk <= 1'b0;
      end else if (!en) begin
         ro_cnt <= '0;
         ro_clk <= 1'b0;
      end else if (ro_cnt == RO_LAST) begin
         ro_cnt <= '0;
         ro_clk <= ~ro_clk;
      end else begin
         ro_cnt <= ro_cnt + RO_W'(1);
      end
   end

   // Free-running fast divider; the strobe is registered off the terminal count.
   always_ff @(posedge clk) begin
      if (!rst) begin
         fast_cnt  <= '0;
         fast_tick <= 1'b0;
      end else begin
         fast_tick <= (fast_cnt == FAST_LAST);
         if (fast_cnt == FAST_LAST) begin
            fast_cnt <= '0;
         end else begin
            fast_cnt <= fast_cnt + FAST_W'(1);
         end
      end
   end

   // Bitwise difference and its population count for the current sample.
   always_comb begin
      diff_c = i1 ^ i2;
      pop_c  = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         pop_c = pop_c + CNT_W'(diff_c[i]);
      end
   end

   // Comparator outputs, all registered from the same sample.
   always_ff @(posedge clk) begin
      if (!rst) begin
         o        <= '0;
         mismatch <= 1'b0;
         diff_cnt <= '0;
      end else begin
         o        <= diff_c;
         mismatch <= |diff_c;
         diff_cnt <= pop_c;
      end
   end

`ifdef CCU_STICKY_ERR_EN
   // Sticky error: latches any registered mismatch until the next reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         err_sticky <= 1'b0;
      end else if (mismatch) begin
         err_sticky <= 1'b1;
      end
   end
`else
   assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_clock_compare_unit.sv
// Directed bench for clock_compare_unit (default parameters: 64 / 4 / 2).
module tb_clock_compare_unit;

   localparam int unsigned WIDTH = 64;
   localparam int unsigned CNT_W = 7;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic [WIDTH-1:0] i1;
   logic [WIDTH-1:0] i2;
   logic             ro_clk;
   logic             fast_tick;
   logic [WIDTH-1:0] o;
   logic             mismatch;
   logic [CNT_W-1:0] diff_cnt;
   logic             err_sticky;

   int checks = 0;
   int errors = 0;

   clock_compare_unit #(.WIDTH(64), .RO_HALF(4), .FAST_DIV(2)) dut (
      .clk(clk), .rst(rst), .en(en), .i1(i1), .i2(i2),
      .ro_clk(ro_clk), .fast_tick(fast_tick), .o(o), .mismatch(mismatch),
      .diff_cnt(diff_cnt), .err_sticky(err_sticky)
   );

   always #5 clk = ~clk;

   // Advance one edge; outputs are then sampled 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; en = 1'b1;
      i1 = 64'hFFFF_FFFF_FFFF_FFFF; i2 = 64'h0;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if ({ro_clk, fast_tick, mismatch, err_sticky} !== 4'b0000 || o !== 64'h0 || diff_cnt !== 7'd0) begin
            errors++;
            $display("FAIL reset cyc%0d: ro=%b ft=%b mm=%b st=%b o=%h cnt=%0d, required all 0",
                     k, ro_clk, fast_tick, mismatch, err_sticky, o, diff_cnt);
         end
      end
      // Release: first fast_tick on the 2nd edge after release, then alternating.
      en = 1'b0; i1 = 64'h0; i2 = 64'h0; rst = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         step();
         checks++;
         if (fast_tick !== ((k % 2) == 0)) begin
            errors++;
            $display("FAIL reset_release_tick edge%0d: got %b required %b", k, fast_tick, (k % 2) == 0);
         end
      end
   endtask

   task automatic test_fast_tick();
      // Reset mid-operation after an odd number of edges: counter must restart.
      step();
      rst = 1'b0; step();
      checks++;
      if (fast_tick !== 1'b0) begin
         errors++;
         $display("FAIL fast_tick_in_reset: got %b required 0", fast_tick);
      end
      rst = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         step();
         checks++;
         if (fast_tick !== ((k % 2) == 0)) begin
            errors++;
            $display("FAIL fast_tick_restart edge%0d: got %b required %b", k, fast_tick, (k % 2) == 0);
         end
      end
   endtask

   task automatic test_ro_enable();
      bit exp;
      en = 1'b1;
      // Edges 1..3 low, 4..7 high, 8..11 low, 12..13 high.
      for (int k = 1; k <= 13; k++) begin
         step();
         exp = ((k / 4) % 2) == 1;
         checks++;
         if (ro_clk !== exp) begin
            errors++;
            $display("FAIL ro_clk edge%0d: got %b required %b", k, ro_clk, exp);
         end
      end
      // Second cycle of the high phase: drop en.
      en = 1'b0; step();
      checks++;
      if (ro_clk !== 1'b0) begin
         errors++;
         $display("FAIL ro_disable: got %b required 0", ro_clk);
      end
      // Re-enable on the next edge: full low phase from count 0.
      en = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         step();
         checks++;
         if (ro_clk !== (k == 4)) begin
            errors++;
            $display("FAIL ro_reenable edge%0d: got %b required %b", k, ro_clk, k == 4);
         end
      end
      en = 1'b0; step();
   endtask

   task automatic test_compare_equal();
      i1 = 64'hDEADBEEF_01234567; i2 = 64'hDEADBEEF_01234567;
      step();
      checks++;
      if (o !== 64'h0 || mismatch !== 1'b0 || diff_cnt !== 7'd0) begin
         errors++;
         $display("FAIL compare_equal: o=%h mm=%b cnt=%0d required o=0 mm=0 cnt=0", o, mismatch, diff_cnt);
      end
   endtask

   task automatic test_compare_diff();
      i1 = 64'hFFFF_FFFF_FFFF_FFFF; i2 = 64'h0;
      step();
      checks++;
      if (o !== 64'hFFFF_FFFF_FFFF_FFFF || mismatch !== 1'b1 || diff_cnt !== 7'd64) begin
         errors++;
         $display("FAIL compare_all: o=%h mm=%b cnt=%0d required o=ffffffffffffffff mm=1 cnt=64", o, mismatch, diff_cnt);
      end
      i1 = 64'h1; i2 = 64'h8000_0000_0000_0001;
      step();
      checks++;
      if (o !== 64'h8000_0000_0000_0000 || mismatch !== 1'b1 || diff_cnt !== 7'd1) begin
         errors++;
         $display("FAIL compare_msb: o=%h mm=%b cnt=%0d required o=8000000000000000 mm=1 cnt=1", o, mismatch, diff_cnt);
      end
      i1 = 64'h0000_0000_0000_00F0; i2 = 64'h0000_0001_0000_000F;
      step();
      checks++;
      if (o !== 64'h0000_0001_0000_00FF || mismatch !== 1'b1 || diff_cnt !== 7'd9) begin
         errors++;
         $display("FAIL compare_mixed: o=%h mm=%b cnt=%0d required o=00000001000000ff mm=1 cnt=9", o, mismatch, diff_cnt);
      end
   endtask

   task automatic test_back_to_back();
      logic [WIDTH-1:0] a, b, x;
      for (int k = 0; k < 100; k++) begin
         a = {$urandom, $urandom};
         b = (k % 4 == 0) ? a : {$urandom, $urandom};
         if (k % 7 == 3) b = a ^ (64'h1 << (k % 64));
         i1 = a; i2 = b;
         step();
         x = a ^ b;
         checks++;
         if (o !== x || mismatch !== (x != 64'h0) || diff_cnt !== CNT_W'($countones(x))) begin
            errors++;
            $display("FAIL back_to_back #%0d: o=%h mm=%b cnt=%0d required o=%h mm=%b cnt=%0d",
                     k, o, mismatch, diff_cnt, x, x != 64'h0, $countones(x));
         end
      end
   endtask

   task automatic test_sticky();
      rst = 1'b0; step(); rst = 1'b1;
      i1 = 64'h5; i2 = 64'h4; step();
      i2 = 64'h5;
      for (int k = 0; k < 10; k++) begin
         step();
         checks++;
`ifdef CCU_STICKY_ERR_EN
         if (err_sticky !== 1'b1) begin
            errors++;
            $display("FAIL sticky_hold cyc%0d: got %b required 1", k, err_sticky);
         end
`else
         if (err_sticky !== 1'b0) begin
            errors++;
            $display("FAIL sticky_off cyc%0d: got %b required 0", k, err_sticky);
         end
`endif
      end
      rst = 1'b0; step();
      checks++;
      if (err_sticky !== 1'b0) begin
         errors++;
         $display("FAIL sticky_clear: got %b required 0", err_sticky);
      end
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0; en = 1'b0; i1 = '0; i2 = '0;
      test_reset();
      test_fast_tick();
      test_ro_enable();
      test_compare_equal();
      test_compare_diff();
      test_back_to_back();
      test_sticky();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/clock_compare_unit.md
# clock_compare_unit

Clock-support and result-check block for the TRNG BIST datapath. It derives a gated ring-oscillator-style clock and a free-running fast tick from the system clock. It also compares the 64-bit hash output against the 64-bit wrapper data, producing a per-bit mismatch vector for the MISR plus summary flags. It sits beside the BIST FSM and feeds the MISR XOR tree.

## Interface
Parameters:
- WIDTH, 64, compared word width (≥2)
- RO_HALF, 4, ro_clk half-period in clk cycles (≥1)
- FAST_DIV, 2, fast_tick period in clk cycles (≥1)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset
- en  in  1  ro_clk enable
- i1  in  WIDTH  hash word
- i2  in  WIDTH  reference (wrapper) word
- ro_clk  out  1  gated divided clock
- fast_tick  out  1  one-cycle strobe every FAST_DIV cycles
- o  out  WIDTH  registered bitwise mismatch, i1 ^ i2
- mismatch  out  1  registered OR-reduce of the mismatch vector
- diff_cnt  out  $clog2(WIDTH+1)  registered count of differing bits (7 bits at 64)
- err_sticky  out  1  sticky mismatch flag (see Configuration)

## Operation
- Reset (rst=0 at a clk edge): ro_clk=0, RO counter=0, fast_tick=0, fast counter=0, o=0, mismatch=0, diff_cnt=0, err_sticky=0. Reset overrides every other input at that edge.
- RO clock:
  - While en=1, the counter increments each cycle. When it equals RO_HALF-1, the counter clears and ro_clk toggles.
  - When en=0 is sampled, the counter clears and ro_clk is forced to 0 at that edge, even mid-high-phase.
  - Re-enabling always starts from the low phase.
- Fast tick:
  - The free-running counter runs 0..FAST_DIV-1 and wraps.
  - fast_tick is registered and is 1 in the cycle after the counter equals FAST_DIV-1.
  - With FAST_DIV=1, fast_tick is constantly 1 from the first cycle after reset.
  - The counter ignores en.
- Comparator:
  - At each edge: o ← i1^i2; mismatch ← |(i1^i2); diff_cnt ← popcount(i1^i2).
  - All three come from the same sample, so they are always mutually consistent.
  - diff_cnt ranges 0..WIDTH, with no overflow.
- All arithmetic is unsigned. Counters are sized $clog2 of their modulus, with a minimum of 1 bit.

## Timing
- Comparator latency: 1 clk. Inputs sampled at edge N appear after edge N. No handshake; the comparator samples every cycle.
- ro_clk:
  - First rising transition occurs RO_HALF edges after the first edge sampling en=1.
  - Period is 2·RO_HALF clk cycles, with 50% duty.
  - Output is registered and glitch-free.
- en deasserted and reasserted on consecutive edges: the low phase restarts from count 0.
- Reset released mid-operation: all counters restart from 0. The first fast_tick occurs FAST_DIV edges after the first edge with rst=1.

## Configuration
- Macro CCU_STICKY_ERR_EN.
- Defined: err_sticky is set at the edge following any cycle where mismatch=1. It holds until rst=0.
- Not defined: err_sticky is tied to 0. The port remains present, and no sticky register is built.

## Test plan
- Reset: hold rst=0 for 3 cycles with en=1 and i1≠i2 → all outputs 0 throughout. Release rst → the first fast_tick occurs on the 2nd cycle (FAST_DIV=2).
- RO enable: en=1 from cycle 0 with RO_HALF=4 → ro_clk rises after edge 4, falls after edge 8, period 8. Drop en at the 2nd cycle of a high phase → ro_clk=0 after that edge, and the counter is cleared.
- Compare equal: i1=i2=64'hDEADBEEF_01234567 → next cycle o=0, mismatch=0, diff_cnt=0.
- Compare differing:
  - i1=64'hFFFF_FFFF_FFFF_FFFF, i2=0 → next cycle o=all ones, mismatch=1, diff_cnt=64.
  - i1=64'h1, i2=64'h8000_0000_0000_0001 → o=64'h8000_0000_0000_0000, diff_cnt=1.
- Back-to-back words: change i1/i2 every cycle for 100 random pairs → each output equals the previous cycle's XOR and popcount exactly.
- Sticky (macro on): one mismatching cycle, then equal words for 10 cycles → err_sticky stays 1 until rst=0. With the macro off, err_sticky stays 0.
